// File: rtl/station_sequencer.sv
// rtl/station_sequencer.sv - station sequencer: line follow, station check, servo pickup/dropoff, load count
module station_sequencer #(
    parameter int NUM_MOTORS    = 2,
    parameter int DEBOUNCE      = 4,
    parameter int SERVO_TIMEOUT = 1000000,
    parameter int CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sw_on,
    input  logic                  pulse,
    input  logic [1:0]            dist_state,
    input  logic                  proximity,
    input  logic [1:0]            ir_state,
    input  logic                  servo_done,
    output logic [NUM_MOTORS-1:0] en,
    output logic                  servo_start,
    output logic                  servo_state,
    output logic [2:0]            state,
    output logic                  fault,
    output logic [CNT_W-1:0]      load_count
);

    localparam int TMR_W = (SERVO_TIMEOUT > 2) ? $clog2(SERVO_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SERVO_TIMEOUT - 1);
    localparam logic [7:0]       DEB       = 8'(DEBOUNCE);
    localparam logic [CNT_W-1:0] LOAD_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FOLLOW  = 3'd1,
        S_CHECK   = 3'd2,
        S_PICKUP  = 3'd3,
        S_DROPOFF = 3'd4,
        S_CLEAR   = 3'd5,
        S_FAULT   = 3'd6,
        S_BAD     = 3'd7
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [7:0]       hi_cnt;
    logic [7:0]       lo_cnt;
    logic [TMR_W-1:0] timer;
    logic             prox_hit;
    logic             prox_gone;
    logic             servo_exit;
    logic             servo_entry;
    logic             in_servo;

    assign prox_hit  = (hi_cnt == DEB);
    assign prox_gone = (lo_cnt == DEB);
    assign in_servo  = (cur_state == S_PICKUP) || (cur_state == S_DROPOFF);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic; servo_done beats the timeout in the same cycle
    always_comb begin
        nxt_state  = cur_state;
        servo_exit = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (sw_on) nxt_state = S_FOLLOW;
            end
            S_FOLLOW: begin
                if (!sw_on)        nxt_state = S_IDLE;
                else if (prox_hit) nxt_state = S_CHECK;
            end
            S_CHECK: begin
                if (dist_state == 2'b01 && ir_state[0]) nxt_state = S_PICKUP;
                else if (dist_state == 2'b10)           nxt_state = S_DROPOFF;
                else                                    nxt_state = S_CLEAR;
            end
            S_PICKUP, S_DROPOFF: begin
                if (servo_done) begin
                    servo_exit = 1'b1;
                    nxt_state  = sw_on ? S_CLEAR : S_IDLE;
                end else if (timer == TMR_LAST) begin
                    nxt_state = S_FAULT;
                end
            end
            S_CLEAR: begin
                if (!sw_on)         nxt_state = S_IDLE;
                else if (prox_gone) nxt_state = S_FOLLOW;
            end
            S_FAULT: begin
                if (!sw_on) nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    assign servo_entry = (cur_state == S_CHECK) &&
                         ((nxt_state == S_PICKUP) || (nxt_state == S_DROPOFF));

    // Proximity run-length counters, saturating at DEBOUNCE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_cnt <= 8'd0;
            lo_cnt <= 8'd0;
        end else if (proximity) begin
            lo_cnt <= 8'd0;
            if (hi_cnt != DEB) hi_cnt <= hi_cnt + 8'd1;
        end else begin
            hi_cnt <= 8'd0;
            if (lo_cnt != DEB) lo_cnt <= lo_cnt + 8'd1;
        end
    end

    // Servo timeout timer, restarted on each servo entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (servo_entry) begin
            timer <= '0;
        end else if (in_servo && timer != TMR_LAST) begin
            timer <= timer + 1'b1;
        end
    end

    // Servo start pulse and held servo mode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            servo_start <= 1'b0;
            servo_state <= 1'b0;
        end else begin
            servo_start <= servo_entry;
            if (servo_entry) servo_state <= (nxt_state == S_DROPOFF);
        end
    end

    // Load count, updated only on a completed servo routine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_count <= '0;
        end else if (servo_exit) begin
            if (cur_state == S_PICKUP && load_count != LOAD_MAX) begin
                load_count <= load_count + 1'b1;
            end else if (cur_state == S_DROPOFF && load_count != '0) begin
                load_count <= load_count - 1'b1;
            end
        end
    end

    assign state = cur_state;
    assign fault = (cur_state == S_FAULT);
    assign en    = ((cur_state == S_FOLLOW || cur_state == S_CLEAR) && sw_on && ir_state[1])
                   ? {NUM_MOTORS{pulse}} : '0;

endmodule

// File: doc/station_sequencer.md
STATION_SEQUENCER -- requirements
Module: station_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk is the only clock, and rst_n is sampled only on the rising edge of clk.
REQ-002 Parameter NUM_MOTORS, default 2: number of motor enable outputs.
REQ-003 Parameter DEBOUNCE, default 4: consecutive cycles needed to qualify a proximity edge, range 1 to 255.
REQ-004 Parameter SERVO_TIMEOUT, default 1000000: maximum cycles to wait for servo_done, at least 2.
REQ-005 Parameter CNT_W, default 4: width of the load counter.
REQ-006 clk  in  1  system clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 sw_on  in  1  run switch; 1 means run.
REQ-009 pulse  in  1  PWM pulse from the motor driver.
REQ-010 dist_state  in  2  station code: 01 is pickup station, 10 is dropoff station, other codes are none.
REQ-011 proximity  in  1  station-present sensor.
REQ-012 ir_state  in  2  bit1 means path detected; bit0 means correct colour at the station.
REQ-013 servo_done  in  1  servo routine complete.
REQ-014 en  out  NUM_MOTORS  motor enables.
REQ-015 servo_start  out  1  one-cycle pulse that starts a servo routine.
REQ-016 servo_state  out  1  servo mode: 0 is pickup, 1 is dropoff.
REQ-017 state  out  3  current FSM state code.
REQ-018 fault  out  1  servo timeout flag.
REQ-019 load_count  out  CNT_W  number of items on board.

Function
REQ-020 State codes SHALL be: IDLE=0, FOLLOW=1, CHECK=2, PICKUP=3, DROPOFF=4, CLEAR=5, FAULT=6; code 7 SHALL go to IDLE on the next cycle.
REQ-021 en SHALL equal {NUM_MOTORS{pulse}} when state is FOLLOW or CLEAR and sw_on=1 and ir_state[1]=1; otherwise en SHALL be all zeros (combinational from the registered state).
REQ-022 Proximity qualification:
- a counter SHALL count consecutive cycles with proximity=1 and clear to 0 on any cycle with proximity=0;
- prox_hit SHALL assert when that count reaches DEBOUNCE;
- prox_gone SHALL assert after DEBOUNCE consecutive cycles with proximity=0.
REQ-023 IDLE: go to FOLLOW when sw_on=1.
REQ-024 FOLLOW: go to IDLE if sw_on=0; otherwise go to CHECK on prox_hit.
REQ-025 CHECK SHALL last exactly one cycle and then go to:
- PICKUP if dist_state=01 and ir_state[0]=1;
- DROPOFF if dist_state=10;
- CLEAR in all other cases.
REQ-026 On entry to PICKUP or DROPOFF:
- servo_start SHALL be 1 for exactly one cycle;
- servo_state SHALL be 0 for PICKUP or 1 for DROPOFF, held until the next entry;
- the timeout timer SHALL clear to 0.
REQ-027 In PICKUP or DROPOFF, servo_done=1 SHALL cause the block to leave the state: go to CLEAR if sw_on=1, or to IDLE if sw_on=0.
REQ-028 On that exit, PICKUP SHALL increment load_count, saturating at 2^CNT_W-1; DROPOFF SHALL decrement load_count, saturating at 0.
REQ-029 In PICKUP or DROPOFF, if the timer reaches SERVO_TIMEOUT-1 with servo_done=0, the block SHALL go to FAULT.
REQ-030 If servo_done and the timeout occur in the same cycle, servo_done SHALL win.
REQ-031 sw_on=0 SHALL NOT abort PICKUP or DROPOFF; the servo routine always completes or times out first.
REQ-032 CLEAR: proximity SHALL be ignored for station entry; go to FOLLOW on prox_gone; go to IDLE if sw_on=0.
REQ-033 FAULT:
- en SHALL be 0 and fault SHALL be 1;
- the block SHALL stay in FAULT until sw_on=0, then go to IDLE with fault cleared in that same transition.
REQ-034 servo_done SHALL be ignored in every state except PICKUP and DROPOFF.
REQ-035 load_count SHALL be preserved across IDLE and FAULT; only reset clears it.

Reset
REQ-036 While rst_n=0 at a clk edge, the block SHALL force state=IDLE, servo_start=0, servo_state=0, fault=0, load_count=0, and clear all counters and timers; en SHALL therefore be 0.
REQ-037 Reset asserted in any state, including mid-servo, SHALL take effect on the next clk edge, and the block SHALL resume in IDLE when rst_n=1.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Pickup path: sw_on=1, ir=11, proximity=1 for 4 cycles, dist=01 -> CHECK, then PICKUP with one servo_start and servo_state=0; servo_done -> CLEAR, load_count=1.
- Dropoff path: load_count=1, dist=10, then servo_done -> DROPOFF with servo_state=1, ending with load_count=0; a second dropoff keeps load_count at 0.
- Debounce: proximity=1 for 3 cycles then 0 -> stays in FOLLOW and en keeps toggling with pulse.
- Timeout: SERVO_TIMEOUT=16, no servo_done -> FAULT after 16 cycles with fault=1 and en=0; sw_on=0 -> IDLE with fault=0.
- Simultaneous events: servo_done on the timeout cycle -> CLEAR, not FAULT; sw_on=0 during PICKUP -> IDLE only after servo_done.
- Reset mid-PICKUP: rst_n=0 for 1 cycle -> state=0, load_count=0, servo_start=0.
